mesh_link_req_arbiter: RTL and testbench
========================================

# mesh_link_req_arbiter

Round-robin arbiter that shares one manycore mesh node's processor-side link among `num_req_p` local requesters. It grants one request packet at a time into a registered output slot and tags each packet's load_id with the requester index. It bounds outstanding packets with a credit counter and steers each return packet back to the requester named in its tag. It sits between local traffic sources (test masters, accelerators) and the `proc_link_sif` port of a `bsg_manycore_mesh_node`.

## Interface
- `num_req_p`, 2, number of requesters, 2..8.
- `max_out_p`, 8, maximum outstanding (issued, unreturned) packets.
- `x_cord_width_p`, "inv", mesh x coordinate width.
- `y_cord_width_p`, "inv", mesh y coordinate width.
- `data_width_p`, 32, packet data width.
- `addr_width_p`, 32, packet address width.
- `load_id_width_p`, 11, load_id width; must be >= `id_width_lp` = max(1, clog2(`num_req_p`)).
- `packet_width_lp` / `return_packet_width_lp`, derived with the `bsg_manycore_packet.vh` width macros.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_v_i`  in  `num_req_p`  per-requester request valid.
- `req_packet_i`  in  `num_req_p`×`packet_width_lp`  per-requester request packet.
- `req_yumi_o`  out  `num_req_p`  one-hot accept; packet consumed this cycle.
- `fwd_v_o`  out  1  forward packet valid (registered).
- `fwd_packet_o`  out  `packet_width_lp`  tagged forward packet (registered).
- `fwd_ready_i`  in  1  link accepts the forward packet.
- `ret_v_i`  in  1  return packet valid.
- `ret_packet_i`  in  `return_packet_width_lp`  return packet.
- `ret_yumi_o`  out  1  return packet consumed.
- `ret_v_o`  out  `num_req_p`  one-hot return valid, steered by tag.
- `ret_packet_o`  out  `return_packet_width_lp`  return packet, broadcast to all requesters.
- `ret_yumi_i`  in  `num_req_p`  per-requester return consume.
- `out_cnt_o`  out  clog2(`max_out_p`+1)  outstanding count.
- `err_o`  out  1  sticky flag: return tag >= `num_req_p`.

## Operation
- Output slot has two states.
  - EMPTY: `fwd_v_o`=0.
  - FULL: `fwd_v_o`=1, holds the packet.
- A grant is allowed when `out_cnt` < `max_out_p`, using the registered count only; a same-cycle return is not counted. It also requires either EMPTY, or FULL with `fwd_ready_i`=1 (back-to-back issue).
- Grant selection: round-robin, starting at `last_ptr`+1 mod `num_req_p`. The first requester with `req_v_i`=1 wins.
- On grant g:
  - `req_yumi_o[g]`=1 combinationally.
  - The slot loads `req_packet_i[g]` with load_id bits [`id_width_lp`-1:0] replaced by g; upper bits are preserved.
  - `last_ptr` ← g; `out_cnt` +1.
- FULL with `fwd_ready_i`=1 and no grant → EMPTY. FULL with `fwd_ready_i`=0 holds the slot stable; no grant.
- Return path is combinational, with id = load_id[`id_width_lp`-1:0] of `ret_packet_i`.
  - If `ret_v_i` and id < `num_req_p`: `ret_v_o[id]`=1 and `ret_yumi_o`=`ret_yumi_i[id]`.
  - If `ret_v_i` and id >= `num_req_p`: `ret_yumi_o`=1 (drop), and `err_o` is set.
- Counter update on a return handshake: `out_cnt` -1; if it is already 0 it stays 0 (no underflow). A grant and a return in the same cycle leave the count unchanged.

## Timing
- Reset (asynchronous): `fwd_v_o`=0, slot EMPTY, `out_cnt`=0, `last_ptr`=`num_req_p`-1 (requester 0 is first), `err_o`=0.
- Combinational outputs are 0 during reset: `req_yumi_o`, `ret_v_o`, `ret_yumi_o`.
- Request-to-`fwd_v_o` latency: 1 cycle. Throughput: 1 packet/cycle while `fwd_ready_i`=1 and credits remain.
- Return path: 0-cycle latency.
- Reset mid-operation drops the held packet. Returns that arrive after reset are still steered; the counter saturates at 0.
- `out_cnt`=`max_out_p`: no grant. The held packet may still drain; a grant resumes the cycle after a return.

## Configuration
- `MESH_LINK_REQ_ARBITER_STATS_EN` defined: adds output `grant_cnt_o` [`num_req_p`×32]. Each requester's counter increments on its grant, wraps at 2^32, and resets to 0.
- Not defined: the port and counters are absent; behaviour is otherwise identical.

## Test plan
- Requesters 0 and 1 both continuously valid, `fwd_ready_i`=1, returns immediate → grants alternate 0,1,0,1; tags 0,1,0,1; `fwd_v_o` is high every cycle from cycle 1.
- `max_out_p`=8, no returns → exactly 8 packets forwarded, then `req_yumi_o`=0 and `out_cnt_o`=8. One return → one further grant the next cycle.
- `fwd_ready_i`=0 for 5 cycles while FULL → `fwd_packet_o` is stable, no `req_yumi_o`; the packet is released on the first ready cycle.
- Return with tag 1 while `ret_yumi_i`=0 for 3 cycles → `ret_v_o`=2'b10 held, `ret_yumi_o`=0, count unchanged until `ret_yumi_i[1]`=1.
- `num_req_p`=3, return tag 3 → `ret_yumi_o`=1, `err_o`=1 sticky until reset, no `ret_v_o`.
- Reset asserted while FULL with `out_cnt`=4 → `fwd_v_o`=0 and `out_cnt_o`=0 immediately. A late return is steered and the count stays 0.

Source files
------------

// File: rtl/mesh_link_req_arbiter_if.sv
// Link-side bundle of mesh_link_req_arbiter: requester fan-in, forward slot,
// return steering, credit count, error flag and slot-state debug output.
interface mesh_link_req_arbiter_if #(
   parameter int num_req_p             = 2,
   parameter int packet_width_p        = 91,
   parameter int return_packet_width_p = 43,
   parameter int cnt_width_p           = 4
);
   // valid/ready: a transfer happens in any cycle where valid and ready/yumi are
   // both high; a valid source holds its payload stable until that cycle.
   logic [num_req_p-1:0]                req_v_i;
   logic [num_req_p*packet_width_p-1:0] req_packet_i;
   logic [num_req_p-1:0]                req_yumi_o;
   logic                                fwd_v_o;
   logic [packet_width_p-1:0]           fwd_packet_o;
   logic                                fwd_ready_i;
   logic                                ret_v_i;
   logic [return_packet_width_p-1:0]    ret_packet_i;
   logic                                ret_yumi_o;
   logic [num_req_p-1:0]                ret_v_o;
   logic [return_packet_width_p-1:0]    ret_packet_o;
   logic [num_req_p-1:0]                ret_yumi_i;
   logic [cnt_width_p-1:0]              out_cnt_o;
   logic                                err_o;
   logic                                slot_state_o;

   modport slave (
      input  req_v_i, req_packet_i, fwd_ready_i, ret_v_i, ret_packet_i, ret_yumi_i,
      output req_yumi_o, fwd_v_o, fwd_packet_o, ret_yumi_o, ret_v_o, ret_packet_o,
             out_cnt_o, err_o, slot_state_o
   );

   modport master (
      output req_v_i, req_packet_i, fwd_ready_i, ret_v_i, ret_packet_i, ret_yumi_i,
      input  req_yumi_o, fwd_v_o, fwd_packet_o, ret_yumi_o, ret_v_o, ret_packet_o,
             out_cnt_o, err_o, slot_state_o
   );
endinterface

// File: rtl/mesh_link_req_arbiter.sv
// Round-robin requester arbiter for a mesh node proc link with credit limit and tag-steered returns.
// Optional per-requester grant counters: define MESH_LINK_REQ_ARBITER_STATS_EN.
module mesh_link_req_arbiter #(
   parameter int num_req_p       = 2,
   parameter int max_out_p       = 8,
   parameter int x_cord_width_p  = 4,
   parameter int y_cord_width_p  = 4,
   parameter int data_width_p    = 32,
   parameter int addr_width_p    = 32,
   parameter int load_id_width_p = 11
) (
   input  logic clk_i,
   input  logic reset_i,
   mesh_link_req_arbiter_if.slave link
`ifdef MESH_LINK_REQ_ARBITER_STATS_EN
   , output logic [num_req_p*32-1:0] grant_cnt_o
`endif
);
   // Packet layouts keep load_id in the low bits:
   // request {addr, data, src_y, src_x, dst_y, dst_x, load_id}, return {data, load_id}.
   localparam int id_width_lp            = (num_req_p > 2) ? $clog2(num_req_p) : 1;
   localparam int cnt_width_lp           = $clog2(max_out_p + 1);
   localparam int packet_width_lp        = addr_width_p + data_width_p
                                         + 2 * x_cord_width_p + 2 * y_cord_width_p
                                         + load_id_width_p;
   localparam int return_packet_width_lp = data_width_p + load_id_width_p;

   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

   slot_state_e                 state_q, state_d;
   logic [packet_width_lp-1:0]  fwd_pkt_q, fwd_pkt_d;
   logic [id_width_lp-1:0]      last_ptr_q, last_ptr_d;
   logic [cnt_width_lp-1:0]     out_cnt_q, out_cnt_d;
   logic                        err_q, err_d;

   logic                        can_issue;
   logic                        gnt_found;
   logic                        grant;
   logic [id_width_lp-1:0]      gnt_idx;
   logic [31:0]                 cand;
   logic [packet_width_lp-1:0]  gnt_pkt;
   logic [id_width_lp-1:0]      ret_id;
   logic                        ret_tag_ok;
   logic                        ret_hs;

   // Credit check uses only the registered count; a same-cycle return frees nothing yet.
   assign can_issue = !reset_i
                    && (out_cnt_q < cnt_width_lp'(max_out_p))
                    && ((state_q == SLOT_EMPTY) || link.fwd_ready_i);

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= num_req_p; i++) begin
         cand = 32'(last_ptr_q) + 32'(i);
         if (cand >= 32'(num_req_p)) cand = cand - 32'(num_req_p);
         if (!gnt_found && link.req_v_i[cand[id_width_lp-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[id_width_lp-1:0];
         end
      end
   end

   assign grant = can_issue && gnt_found;

   always_comb begin
      gnt_pkt = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (gnt_idx == id_width_lp'(i)) gnt_pkt = link.req_packet_i[i*packet_width_lp +: packet_width_lp];
      end
      gnt_pkt[id_width_lp-1:0] = gnt_idx;
   end

   always_comb begin
      link.req_yumi_o = '0;
      if (grant) link.req_yumi_o[gnt_idx] = 1'b1;
   end

   assign ret_id     = link.ret_packet_i[id_width_lp-1:0];
   assign ret_tag_ok = (32'(ret_id) < 32'(num_req_p));

   // Returns carrying an impossible tag are swallowed so they cannot block the link.
   always_comb begin
      link.ret_v_o    = '0;
      link.ret_yumi_o = 1'b0;
      if (!reset_i && link.ret_v_i) begin
         if (ret_tag_ok) begin
            link.ret_v_o[ret_id] = 1'b1;
            link.ret_yumi_o      = link.ret_yumi_i[ret_id];
         end else begin
            link.ret_yumi_o = 1'b1;
         end
      end
   end

   assign ret_hs = link.ret_v_i && link.ret_yumi_o;

   always_comb begin
      state_d    = state_q;
      fwd_pkt_d  = fwd_pkt_q;
      last_ptr_d = last_ptr_q;
      out_cnt_d  = out_cnt_q;
      err_d      = err_q | (link.ret_v_i && !ret_tag_ok);
      if (grant) begin
         state_d    = SLOT_FULL;
         fwd_pkt_d  = gnt_pkt;
         last_ptr_d = gnt_idx;
      end else if ((state_q == SLOT_FULL) && link.fwd_ready_i) begin
         state_d = SLOT_EMPTY;
      end
      if (grant && !ret_hs) begin
         out_cnt_d = out_cnt_q + cnt_width_lp'(1);
      end else if (!grant && ret_hs && (out_cnt_q != '0)) begin
         out_cnt_d = out_cnt_q - cnt_width_lp'(1);
      end
   end

`ifdef MESH_LINK_REQ_ARBITER_STATS_EN
   logic [num_req_p-1:0][31:0] grant_cnt_q, grant_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if (grant) grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + 32'd1;
   end

   assign grant_cnt_o = grant_cnt_q;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= SLOT_EMPTY;
         fwd_pkt_q  <= '0;
         last_ptr_q <= id_width_lp'(num_req_p - 1);
         out_cnt_q  <= '0;
         err_q      <= 1'b0;
`ifdef MESH_LINK_REQ_ARBITER_STATS_EN
         grant_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         fwd_pkt_q  <= fwd_pkt_d;
         last_ptr_q <= last_ptr_d;
         out_cnt_q  <= out_cnt_d;
         err_q      <= err_d;
`ifdef MESH_LINK_REQ_ARBITER_STATS_EN
         grant_cnt_q <= grant_cnt_d;
`endif
      end
   end

   assign link.fwd_v_o      = (state_q == SLOT_FULL);
   assign link.fwd_packet_o = fwd_pkt_q;
   assign link.out_cnt_o    = out_cnt_q;
   assign link.err_o        = err_q;
   assign link.ret_packet_o = link.ret_packet_i;
   assign link.slot_state_o = state_q;
endmodule

// File: tb/tb_mesh_link_req_arbiter.sv
// Bench for mesh_link_req_arbiter (3 requesters, 8 credits): per-cycle vector table
// plus reset/error sequences; forwarded packets are checked against an expected queue.
module tb_mesh_link_req_arbiter;
   localparam int NR = 3;
   localparam int MO = 8;
   localparam int PW = 91;
   localparam int RW = 43;
   localparam int CW = 4;

   typedef struct {
      logic          rst;
      logic [NR-1:0] req_v;
      logic          fwd_ready;
      logic          ret_v;
      logic [1:0]    ret_tag;
      logic [NR-1:0] ret_yumi;
      logic [NR-1:0] e_yumi;
      logic [NR-1:0] e_ret_v;
      logic          e_ret_yumi;
      logic          e_fwd_v;
      logic [CW-1:0] e_cnt;
      logic          e_err;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;
   vec_t vt[$];
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] drv_pkt [NR];

   mesh_link_req_arbiter_if #(
      .num_req_p(NR), .packet_width_p(PW), .return_packet_width_p(RW), .cnt_width_p(CW)
   ) link ();

`ifdef MESH_LINK_REQ_ARBITER_STATS_EN
   logic [NR*32-1:0] grant_cnt;
`endif

   mesh_link_req_arbiter #(
      .num_req_p(NR), .max_out_p(MO), .x_cord_width_p(4), .y_cord_width_p(4),
      .data_width_p(32), .addr_width_p(32), .load_id_width_p(11)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .link    (link)
`ifdef MESH_LINK_REQ_ARBITER_STATS_EN
      , .grant_cnt_o (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [NR-1:0] req_v, input logic rdy,
                               input logic rv, input logic [1:0] tag, input logic [NR-1:0] ry,
                               input logic [NR-1:0] ey, input logic [NR-1:0] erv, input logic ery,
                               input logic efv, input logic [CW-1:0] ecnt, input logic eerr);
      vec_t v;
      v.rst = r; v.req_v = req_v; v.fwd_ready = rdy; v.ret_v = rv; v.ret_tag = tag;
      v.ret_yumi = ry; v.e_yumi = ey; v.e_ret_v = erv; v.e_ret_yumi = ery;
      v.e_fwd_v = efv; v.e_cnt = ecnt; v.e_err = eerr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the clock edge; outputs are sampled 1 unit later.
   task automatic run_vec(input vec_t v, input string tag);
      logic [PW-1:0] pkt;
      logic [PW-1:0] exp_pkt;
      logic [RW-1:0] rpkt;
      rst = v.rst;
      for (int r = 0; r < NR; r++) begin
         pkt = {32'($urandom), 32'($urandom), 16'($urandom), 9'($urandom), 2'b11};
         drv_pkt[r] = pkt;
         link.req_packet_i[r*PW +: PW] = pkt;
      end
      rpkt = {32'($urandom), 9'($urandom), v.ret_tag};
      link.req_v_i      = v.req_v;
      link.fwd_ready_i  = v.fwd_ready;
      link.ret_v_i      = v.ret_v;
      link.ret_packet_i = rpkt;
      link.ret_yumi_i   = v.ret_yumi;
      if (v.rst) exp_q.delete();
      for (int g = 0; g < NR; g++) begin
         if (v.e_yumi[g]) begin
            exp_pkt = drv_pkt[g];
            exp_pkt[1:0] = 2'(g);
            exp_q.push_back(exp_pkt);
         end
      end
      #1;
      chk({tag, " req_yumi"}, 128'(link.req_yumi_o), 128'(v.e_yumi));
      chk({tag, " ret_v"}, 128'(link.ret_v_o), 128'(v.e_ret_v));
      chk({tag, " ret_yumi"}, 128'(link.ret_yumi_o), 128'(v.e_ret_yumi));
      chk({tag, " fwd_v"}, 128'(link.fwd_v_o), 128'(v.e_fwd_v));
      chk({tag, " out_cnt"}, 128'(link.out_cnt_o), 128'(v.e_cnt));
      chk({tag, " err"}, 128'(link.err_o), 128'(v.e_err));
      if (v.ret_v) chk({tag, " ret_packet"}, 128'(link.ret_packet_o), 128'(rpkt));
      if (v.e_fwd_v) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s fwd_packet: got %0h expected none queued", tag, link.fwd_packet_o);
         end else begin
            chk({tag, " fwd_packet"}, 128'(link.fwd_packet_o), 128'(exp_q[0]));
            if (v.fwd_ready) void'(exp_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      rst = 1'b1;
      link.req_v_i = '0; link.req_packet_i = '0; link.fwd_ready_i = 1'b0;
      link.ret_v_i = 1'b0; link.ret_packet_i = '0; link.ret_yumi_i = '0;

      // Two requesters, immediate returns: grants and tags alternate 0,1,0,1.
      vt.push_back(mk(1'b0, 3'b011, 1'b1, 1'b0, 2'd0, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0));
      vt.push_back(mk(1'b0, 3'b011, 1'b1, 1'b1, 2'd0, 3'b111, 3'b010, 3'b001, 1'b1, 1'b1, 4'd1, 1'b0));
      vt.push_back(mk(1'b0, 3'b011, 1'b1, 1'b1, 2'd1, 3'b111, 3'b001, 3'b010, 1'b1, 1'b1, 4'd1, 1'b0));
      vt.push_back(mk(1'b0, 3'b011, 1'b1, 1'b1, 2'd0, 3'b111, 3'b010, 3'b001, 1'b1, 1'b1, 4'd1, 1'b0));
      vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 3'b111, 3'b000, 3'b010, 1'b1, 1'b1, 4'd1, 1'b0));
      vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0));
      // Credit exhaustion: eight grants to requester 2, then stall until a return.
      vt.push_back(mk(1'b0, 3'b100, 1'b1, 1'b0, 2'd0, 3'b000, 3'b100, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0));
      for (int k = 1; k <= 7; k++)
         vt.push_back(mk(1'b0, 3'b100, 1'b1, 1'b0, 2'd0, 3'b000, 3'b100, 3'b000, 1'b0, 1'b1, CW'(k), 1'b0));
      vt.push_back(mk(1'b0, 3'b100, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 4'd8, 1'b0));
      vt.push_back(mk(1'b0, 3'b100, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 4'd8, 1'b0));
      vt.push_back(mk(1'b0, 3'b100, 1'b1, 1'b1, 2'd2, 3'b111, 3'b000, 3'b100, 1'b1, 1'b0, 4'd8, 1'b0));
      vt.push_back(mk(1'b0, 3'b100, 1'b1, 1'b0, 2'd0, 3'b000, 3'b100, 3'b000, 1'b0, 1'b0, 4'd7, 1'b0));
      vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 4'd8, 1'b0));
      // Return tag 1 stalled by its requester, then consumed.
      vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 4'd8, 1'b0));
      vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 4'd8, 1'b0));
      vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 3'b101, 3'b000, 3'b010, 1'b0, 1'b0, 4'd8, 1'b0));
      vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 3'b000, 3'b010, 1'b1, 1'b0, 4'd8, 1'b0));
      for (int k = 7; k >= 4; k--)
         vt.push_back(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 3'b111, 3'b000, 3'b001, 1'b1, 1'b0, CW'(k), 1'b0));
      // Back-pressure: slot held for five cycles, released on the first ready cycle.
      vt.push_back(mk(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 4'd3, 1'b0));
      for (int k = 0; k < 5; k++)
         vt.push_back(mk(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 4'd4, 1'b0));
      vt.push_back(mk(1'b0, 3'b011, 1'b1, 1'b0, 2'd0, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1, 4'd4, 1'b0));
      vt.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 3'b111, 3'b000, 3'b010, 1'b1, 1'b1, 4'd5, 1'b0));

      repeat (2) @(posedge clk);
      #1;
      run_vec(mk(1'b1, 3'b111, 1'b1, 1'b1, 2'd1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0), "reset");

      foreach (vt[i]) run_vec(vt[i], $sformatf("v%0d", i));

      // Reset while FULL with four outstanding, then a late return.
      run_vec(mk(1'b1, 3'b011, 1'b1, 1'b1, 2'd0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0), "rst_mid");
      run_vec(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 4'd0, 1'b0), "late_ret");
      run_vec(mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0), "cnt_sat");
      // Impossible tag: dropped, error flag sticks until the next reset.
      run_vec(mk(1'b0, 3'b000, 1'b1, 1'b1, 2'd3, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 4'd0, 1'b0), "bad_tag");
      run_vec(mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 4'd0, 1'b1), "err_set");
      run_vec(mk(1'b0, 3'b011, 1'b1, 1'b0, 2'd0, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 4'd0, 1'b1), "ptr_reset");
      run_vec(mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 4'd1, 1'b1), "err_hold");
      chk("scoreboard drained", 128'(exp_q.size()), 128'(0));
      run_vec(mk(1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0), "err_clear");
      run_vec(mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0), "idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
